// File: rtl/spi_gray_pkg.sv
// Definitions shared by the SPI execution unit's Gray encoder and the
// bit-serial Gray decoder: FSM states, error-code fill and the decode step.
package spi_gray_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } gray_state_e;

    // The encoder flags a negative source with an all-ones word; this is the fill bit.
    localparam logic ERR_FILL = 1'b1;

    // One Gray-to-binary step: the next binary bit down from the previous one.
    function automatic logic gray_step(input logic prev_bit, input logic gray_bit);
        return prev_bit ^ gray_bit;
    endfunction

    // Any word with the MSB set (including the all-ones error code) is invalid.
    function automatic logic gray_is_err(input logic gray_msb);
        return gray_msb == ERR_FILL;
    endfunction

endpackage

// File: rtl/gray_decoder_seq.sv
// Bit-serial Gray-to-binary decoder: one LEN-bit word per handshake,
// one binary bit resolved per clock, MSB first, signed result with error flag.
module gray_decoder_seq
    import spi_gray_pkg::*;
#(
    parameter int LEN = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [LEN-1:0]        i_gray,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic signed [LEN-1:0] o_data,
    output logic                  o_err,
    output logic                  o_valid,
    input  logic                  i_ready
);

    localparam int IDXW = $clog2(LEN);

    gray_state_e     state_q, state_d;
    logic [LEN-2:0]  gray_q,  gray_d;   // remaining Gray bits, next one at the top
    logic [LEN-2:0]  res_q,   res_d;    // binary bits resolved so far, newest at bit 0
    logic [IDXW-1:0] idx_q,   idx_d;
    logic [LEN-1:0]  data_q,  data_d;
    logic            err_q,   err_d;
    logic            step_bit;
    logic [LEN-1:0]  res_next;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d  = state_q;
        gray_d   = gray_q;
        res_d    = res_q;
        idx_d    = idx_q;
        data_d   = data_q;
        err_d    = err_q;
        step_bit = gray_step(res_q[0], gray_q[LEN-2]);
        res_next = {res_q, step_bit};

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    gray_d = i_gray[LEN-2:0];
                    if (gray_is_err(i_gray[LEN-1])) begin
                        data_d  = {LEN{ERR_FILL}};
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        res_d   = '0;
                        idx_d   = IDXW'(LEN - 2);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                gray_d = gray_q << 1;
                res_d  = res_next[LEN-2:0];
                if (idx_q == '0) begin
                    data_d  = res_next;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            gray_q  <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gray_q  <= gray_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_valid = (state_q == DONE);
    assign o_data  = $signed(data_q);
    assign o_err   = err_q;

endmodule

// File: doc/gray_decoder_seq.md
# gray_decoder_seq

Sequential, bit-serial Gray-to-binary decoder for the SPI execution unit; the receiving counterpart of the unit's combinational Gray encoder. It accepts one LEN-bit Gray word per valid/ready handshake and resolves one binary bit per clock, MSB first. It returns a signed binary result with its own handshake. It recognises the encoder's all-ones error code, and any Gray word with MSB set, as an invalid (negative) source value and flags it.

## Interface
- LEN, 4, word width in bits; legal range 2..32.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_gray  in  LEN  Gray-coded input word.
- i_valid  in  1  input word present.
- o_ready  out  1  decoder can accept a word; high only in IDLE.
- o_data  out  LEN (signed)  decoded binary value; held stable while o_valid is high.
- o_err  out  1  result is the error code; qualified by o_valid.
- o_valid  out  1  result available.
- i_ready  in  1  consumer takes the result.

## Operation
- Reset: state IDLE. o_ready=1, o_valid=0, o_err=0, o_data=0. Internal shift/index registers are cleared.
- Decoding rule: b[LEN-1]=g[LEN-1]; b[i]=b[i+1]^g[i] for i=LEN-2..0.
- IDLE: on i_valid && o_ready, capture i_gray.
  - If i_gray[LEN-1]=1 (covers the all-ones error code): o_data='1 (-1), o_err=1, go to DONE.
  - Otherwise: b[LEN-1]=0, index=LEN-2, go to RUN.
- RUN: each cycle, compute b[index] from the previously computed bit and the captured g[index], then decrement index.
  - When the bit at index 0 is computed, load o_data with the full result, set o_err=0, go to DONE.
  - i_valid is ignored and o_ready=0 throughout RUN.
- DONE: o_valid=1; o_data and o_err are held.
  - On i_ready=1: go to IDLE, o_valid=0 next cycle. o_data keeps its last value; only o_valid qualifies it.
  - While i_ready=0: hold indefinitely.
- Transitions: IDLE→RUN, IDLE→DONE (error path), RUN→RUN, RUN→DONE, DONE→IDLE. Any state→IDLE on i_rst.
- Reset mid-operation (RUN or DONE): the word is discarded with no o_valid pulse, and all outputs return to their reset values next cycle.
- Input changes on i_gray after capture have no effect.
- Index counter width is $clog2(LEN). It never wraps: RUN exits when index reaches 0.

## Timing
- Handshake accepted at edge k.
- Normal path: RUN occupies edges k+1..k+LEN-1. o_valid rises after edge k+LEN-1, so latency is LEN-1 cycles (3 for LEN=4).
- Error path: o_valid rises after edge k (1 cycle).
- Output acceptance: o_valid && i_ready at edge m → IDLE at m, o_ready=1 in cycle m+1.
- Next accept is possible at edge m+1, so there is exactly one bubble cycle.
- Maximum throughput: one word per LEN+1 cycles when i_ready is held high.
- i_valid and i_ready are sampled only on rising edges. No combinational path from i_ready to o_ready or from i_valid to o_valid.

## Structure
- Shared package spi_gray_pkg holds:
  - state typedef enum {IDLE, RUN, DONE};
  - the error-code convention (all-ones), shared with the encoder;
  - the function computing the decode step bit.
- Single module: FSM, index counter and result register.
- No sub-module; the datapath is one XOR stage plus registers.

## Test plan
- Reset, then LEN=4, i_gray=4'b0110 with i_valid=1, i_ready=1 → o_valid after 3 cycles, o_data=4 (0100), o_err=0; o_ready=1 in the cycle after acceptance.
- Exhaustive round trip through the unit's Gray encoder for binary 0..7 → o_data equals the original value every time, o_err=0; a scoreboard checks LEN+1 cycle spacing.
- i_gray=4'b1111 (encoder error code), then 4'b1000 → each gives o_valid 1 cycle after accept, o_data=-1, o_err=1.
- Backpressure: decode 4'b0100 (expect 7) with i_ready=0 for 5 cycles → o_valid and o_data=7 held stable, o_ready=0; i_valid pulses during the stall are ignored; release i_ready → single transfer.
- i_rst asserted at the second RUN cycle → next cycle o_valid=0, o_ready=1, o_data=0; a subsequent word 4'b0011 decodes to 2 correctly.
- LEN=8 instance, i_gray=8'b0111_1111 → o_data=85 (0101_0101) after 7 cycles.
